// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin owner of one shared 16-way resource.
// A winner is chosen in IDLE, held in GRANT until it drops its request or
// reaches MAX_HOLD cycles, then the bus idles for one RELEASE cycle before
// the next arbitration. gnt is the decoded, valid-gated form of gnt_idx.

// 4-to-16 one-hot decoder with an enable; output is zero when disabled.
module dec4to16 (
   input  logic [3:0]  sel,
   input  logic        en,
   output logic [15:0] dec
);

   // One-hot decode of sel, forced to zero while en is low.
   always_comb begin
      dec = 16'h0000;
      if (en) begin
         dec[sel] = 1'b1;
      end else begin
         dec = 16'h0000;
      end
   end

endmodule

module rr_grant_scheduler #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_valid,
   output logic        timeout
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [3:0]       ptr_r;
   logic [3:0]       ptr_nxt_s;
   logic [3:0]       idx_r;
   logic [3:0]       idx_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             timeout_r;
   logic             timeout_nxt_s;
   logic [3:0]       winner_s;
   logic [3:0]       cand_s;
   logic             found_s;
   logic             owner_req_s;
   logic             hold_done_s;
   logic             gnt_valid_s;

   assign owner_req_s = req[idx_r];
   assign hold_done_s = (cnt_r == HOLD_LAST);

   // Upward search from ptr with wrap; the first set request wins.
   always_comb begin
      winner_s = 4'd0;
      found_s  = 1'b0;
      cand_s   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         cand_s   = ptr_r + 4'(i);
         winner_s = (!found_s && req[cand_s]) ? cand_s : winner_s;
         found_s  = found_s | req[cand_s];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: GRANT ends on request drop or hold limit, RELEASE lasts one cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en && found_s) begin
               state_nxt_s = ST_GRANT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!owner_req_s || hold_done_s) begin
               state_nxt_s = ST_RELEASE;
            end else begin
               state_nxt_s = ST_GRANT;
            end
         end
         ST_RELEASE: state_nxt_s = ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs: a grant is live only in GRANT.
   always_comb begin
      gnt_valid_s = 1'b0;
      case (state_r)
         ST_GRANT: gnt_valid_s = 1'b1;
         default:  gnt_valid_s = 1'b0;
      endcase
   end

   // Datapath next values: pointer, grantee index, hold counter, timeout pulse.
   always_comb begin
      ptr_nxt_s     = ptr_r;
      idx_nxt_s     = idx_r;
      cnt_nxt_s     = cnt_r;
      timeout_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en && found_s) begin
               ptr_nxt_s = winner_s + 4'd1;
               idx_nxt_s = winner_s;
               cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
               ptr_nxt_s = ptr_r;
            end
         end
         ST_GRANT: begin
            if (!owner_req_s) begin
               timeout_nxt_s = 1'b0;
            end else if (hold_done_s) begin
               timeout_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            timeout_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r     <= 4'd0;
         idx_r     <= 4'd0;
         cnt_r     <= {CNT_W{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         ptr_r     <= ptr_nxt_s;
         idx_r     <= idx_nxt_s;
         cnt_r     <= cnt_nxt_s;
         timeout_r <= timeout_nxt_s;
      end
   end

   dec4to16 u_dec (
      .sel (idx_r),
      .en  (gnt_valid_s),
      .dec (gnt)
   );

   assign gnt_idx   = idx_r;
   assign gnt_valid = gnt_valid_s;
   assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Testbench for rr_grant_scheduler: stimulus pushes predicted outputs into a
// scoreboard queue, a monitor pops and compares after every clock edge.
module tb_rr_grant_scheduler;

   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [15:0] req = 16'h0000;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   rr_grant_scheduler #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] gnt;
      logic [3:0]  idx;
      logic        idx_chk;
      logic        valid;
      logic        tmo;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: owner (-1 = bus free), cycles held, pending idle gap.
   int         m_owner   = -1;
   int         m_h       = 0;
   int         m_gap     = 0;
   int         m_ptr     = 0;
   logic [3:0] m_idx     = 4'd0;
   logic       m_idx_chk = 1'b1;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_edge(input logic [15:0] r, input logic e, input logic rs);
      exp_t        x;
      logic [15:0] one16;
      int          best;
      int          bestd;
      int          d;
      one16 = 16'h0001;
      x.tmo = 1'b0;
      if (rs) begin
         m_owner = -1; m_h = 0; m_gap = 0; m_ptr = 0;
         m_idx = 4'd0; m_idx_chk = 1'b1;
      end else if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1; m_gap = 1;
         end else if (m_h == MAX_HOLD) begin
            x.tmo = 1'b1; m_owner = -1; m_gap = 1;
         end else begin
            m_h++;
         end
      end else if (m_gap > 0) begin
         m_gap = 0; m_idx_chk = 1'b0;
      end else if (e && r != 16'h0000) begin
         best = -1; bestd = 99;
         for (int i = 0; i < 16; i++) begin
            d = (i - m_ptr + 16) % 16;
            if (r[i] && d < bestd) begin
               bestd = d; best = i;
            end
         end
         m_owner = best; m_h = 1; m_ptr = (best + 1) % 16;
         m_idx = 4'(best); m_idx_chk = 1'b1;
      end
      x.valid   = (m_owner >= 0);
      x.gnt     = x.valid ? (one16 << m_owner) : 16'h0000;
      x.idx     = m_idx;
      x.idx_chk = m_idx_chk;
      sb_q.push_back(x);
   endtask

   task automatic step(input logic [15:0] r, input logic e, input logic rs);
      @(negedge clk);
      req = r; en = e; rst = rs;
      model_edge(r, e, rs);
   endtask

   // Requesters in base assert req; the owner drops its bit once held for 'hold' cycles.
   task automatic agent(input logic [15:0] base, input int hold, input int ncyc, input logic e);
      logic [15:0] r;
      for (int n = 0; n < ncyc; n++) begin
         r = base;
         if (m_owner >= 0 && m_h >= hold) r[m_owner] = 1'b0;
         step(r, e, 1'b0);
      end
   endtask

   // Monitor: compare DUT outputs after each edge against the oldest prediction.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("gnt", gnt, x.gnt);
            check("gnt_valid", {15'd0, gnt_valid}, {15'd0, x.valid});
            check("timeout", {15'd0, timeout}, {15'd0, x.tmo});
            if (x.idx_chk) check("gnt_idx", {12'd0, gnt_idx}, {12'd0, x.idx});
         end
      end
   end

   initial begin
      logic [15:0] base;
      int          hold;
      logic        e;

      // reset and basic grant/release
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0001, 1'b1, 1'b0);
      step(16'h0001, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) step(16'h0000, 1'b1, 1'b0);

      // round-robin order with 2-cycle holds
      agent(16'h8421, 2, 24, 1'b1);
      agent(16'h0000, 9, 3, 1'b1);

      // wrap-around: grant 14, then 15 and 0 compete
      agent(16'h4000, 2, 5, 1'b1);
      agent(16'h8001, 2, 12, 1'b1);
      agent(16'h0000, 9, 3, 1'b1);

      // timeout with a sole persistent requester
      agent(16'h0008, 99, 20, 1'b1);
      agent(16'h0000, 9, 3, 1'b1);

      // timeout while others request: the others win next
      agent(16'h0108, 99, 16, 1'b1);
      agent(16'h0000, 9, 3, 1'b1);

      // release on the same edge the hold limit is reached
      agent(16'h0004, MAX_HOLD, 10, 1'b1);
      agent(16'h0000, 9, 3, 1'b1);

      // en low in IDLE holds off arbitration; en low during GRANT is ignored
      agent(16'h0300, 99, 4, 1'b0);
      agent(16'h0300, 3, 2, 1'b1);
      agent(16'h0300, 3, 4, 1'b0);
      agent(16'h0000, 9, 3, 1'b1);

      // async reset mid-grant
      agent(16'h0040, 99, 3, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_gnt", gnt, 16'h0000);
      check("rst_gnt_valid", {15'd0, gnt_valid}, 16'h0000);
      check("rst_gnt_idx", {12'd0, gnt_idx}, 16'h0000);
      step(16'h0040, 1'b1, 1'b1);
      agent(16'h0041, 2, 8, 1'b1);
      agent(16'h0000, 9, 3, 1'b1);

      // randomized traffic
      base = 16'h0000; hold = 1;
      for (int n = 0; n < 400; n++) begin
         if (n % 8 == 0) begin
            base = 16'($urandom) & 16'($urandom);
            hold = $urandom_range(1, 6);
         end
         e = ($urandom_range(0, 7) != 0);
         agent(base, hold, 1, e);
      end
      agent(16'h0000, 9, 4, 1'b1);

      repeat (3) @(posedge clk);
      #3;
      check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
